uart_program_loader: RTL

- Parametrised in-fabric successor to the vendor UART programming core used for the CPU's UART mode.
- Receives a length-prefixed image over a UART line and writes it word by word into IMem/DMem.
- Addresses are contiguous; the address MSB selects DMem.
- Reports completion or failure to the host with a one-byte reply on tx.
- Exposes done/busy/err so the top level can gate the CPU clock and reset.

---
 rtl/uart_loader_pkg.sv | 37 +++
 rtl/uart_byte_rx.sv | 91 +++++++++
 rtl/uart_program_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader: FSM state encodings,
// host reply bytes and a constant clog2 used to size counters.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] NAK_BYTE = 8'h45;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection, LSB-first
// deserializer. Emits one-cycle byte-valid or framing-error pulses.
module uart_byte_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frameErr
);

  localparam int CW = clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic            r_rxMeta;
  logic            r_rxSync;
  logic            r_rxPrev;
  rx_state_e       r_state;
  logic [CW-1:0]   r_clkCnt;
  logic [2:0]      r_bitCnt;
  logic [7:0]      r_shift;
  logic            r_valid;
  logic            r_frameErr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_rxPrev   <= 1'b1;
      r_state    <= RX_IDLE;
      r_clkCnt   <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_rxMeta   <= i_rx;
      r_rxSync   <= r_rxMeta;
      r_rxPrev   <= r_rxSync;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_clkCnt <= '0;
          r_bitCnt <= '0;
          if (r_rxPrev && !r_rxSync) r_state <= RX_START;
        end
        // A start bit that is high again at mid-bit was only a glitch.
        RX_START: begin
          if (r_clkCnt == HALF_BIT) begin
            r_clkCnt <= '0;
            r_state  <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clkCnt == FULL_BIT) begin
            r_clkCnt <= '0;
            r_shift  <= {r_rxSync, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) r_state <= RX_STOP;
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clkCnt == FULL_BIT) begin
            r_clkCnt <= '0;
            r_state  <= RX_IDLE;
            if (r_rxSync) r_valid    <= 1'b1;
            else          r_frameErr <= 1'b1;
          end else begin
            r_clkCnt <= r_clkCnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte     = r_shift;
  assign o_valid    = r_valid;
  assign o_frameErr = r_frameErr;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a length-prefixed image from UART into IMem/DMem and replies 'K' or 'E'.
// Optional trailing XOR checksum byte enabled by UART_PROGRAM_LOADER_CHECKSUM_EN.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 15,
  parameter int LEN_BYTES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic              tx,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BPW = DATA_W / 8;
  localparam int LW  = 8 * LEN_BYTES;
  localparam int CW  = ((LW > ADDR_W + 1) ? LW : ADDR_W + 1) + 1;
  localparam int BCW = clog2(BPW) + 1;
  localparam int LCW = clog2(LEN_BYTES) + 1;
  localparam int TCW = clog2(CLKS_PER_BIT) + 1;
  localparam logic [TCW-1:0] TX_FULL = TCW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  MAX_WORDS = CW'(1) << ADDR_W;

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_e POST_DATA = ST_CSUM;
`else
  localparam loader_state_e POST_DATA = ST_ACK;
`endif

  logic [7:0]        w_byte;
  logic              w_byteValid;
  logic              w_frameErr;
  logic [LW-1:0]     w_newLen;
  logic [DATA_W-1:0] w_newWord;
  logic [CW-1:0]     w_newLenExt;
  logic [CW-1:0]     w_lenExt;

  loader_state_e     r_state;
  logic [LW-1:0]     r_len;
  logic [LCW-1:0]    r_lenCnt;
  logic [DATA_W-1:0] r_word;
  logic [BCW-1:0]    r_byteCnt;
  logic [CW-1:0]     r_wordIdx;
  logic [7:0]        r_csum;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [9:0]        r_txFrame;
  logic [TCW-1:0]    r_txClk;
  logic [3:0]        r_txBit;
  logic              r_txBusy;
  logic              r_txSent;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byteRx (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (rx),
    .o_byte     (w_byte),
    .o_valid    (w_byteValid),
    .o_frameErr (w_frameErr)
  );

  // Merge the incoming byte into the length/word being assembled, little-endian.
  always_comb begin
    w_newLen                      = r_len;
    w_newLen[8*r_lenCnt +: 8]     = w_byte;
    w_newWord                     = r_word;
    w_newWord[8*r_byteCnt +: 8]   = w_byte;
    w_newLenExt                   = CW'(w_newLen);
    w_lenExt                      = CW'(r_len);
  end

  // Dropping start anywhere outside IDLE behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || (!start && r_state != ST_IDLE)) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_lenCnt  <= '0;
      r_word    <= '0;
      r_byteCnt <= '0;
      r_wordIdx <= '0;
      r_csum    <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_txFrame <= '1;
      r_txClk   <= '0;
      r_txBit   <= '0;
      r_txBusy  <= 1'b0;
      r_txSent  <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (r_txBusy) begin
        if (r_txClk == TX_FULL) begin
          r_txClk   <= '0;
          r_txFrame <= {1'b1, r_txFrame[9:1]};
          r_txBit   <= r_txBit + 1'b1;
          if (r_txBit == 4'd9) begin
            r_txBusy <= 1'b0;
            r_txSent <= 1'b1;
          end
        end else begin
          r_txClk <= r_txClk + 1'b1;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_LEN;
        end
        ST_LEN: begin
          if (w_frameErr) begin
            r_state <= ST_ERROR;
          end else if (w_byteValid) begin
            r_len <= w_newLen;
            if (r_lenCnt == LCW'(LEN_BYTES - 1)) begin
              r_lenCnt <= '0;
              if (w_newLenExt == '0)            r_state <= POST_DATA;
              else if (w_newLenExt > MAX_WORDS) r_state <= ST_ERROR;
              else                              r_state <= ST_DATA;
            end else begin
              r_lenCnt <= r_lenCnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_frameErr) begin
            r_state <= ST_ERROR;
          end else if (w_byteValid) begin
            r_csum <= r_csum ^ w_byte;
            if (r_byteCnt == BCW'(BPW - 1)) begin
              r_byteCnt <= '0;
              r_word    <= '0;
              r_wen     <= 1'b1;
              r_addr    <= r_wordIdx[ADDR_W-1:0];
              r_wdata   <= w_newWord;
              r_wordIdx <= r_wordIdx + 1'b1;
              if (r_wordIdx + 1'b1 == w_lenExt) r_state <= POST_DATA;
            end else begin
              r_word    <= w_newWord;
              r_byteCnt <= r_byteCnt + 1'b1;
            end
          end
        end
        ST_CSUM: begin
          if (w_frameErr)       r_state <= ST_ERROR;
          else if (w_byteValid) r_state <= (w_byte == r_csum) ? ST_ACK : ST_ERROR;
        end
        ST_ACK: begin
          if (r_txSent) begin
            r_state <= ST_DONE;
          end else if (!r_txBusy) begin
            r_txFrame <= {1'b1, ACK_BYTE, 1'b0};
            r_txClk   <= '0;
            r_txBit   <= '0;
            r_txBusy  <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (!r_txBusy && !r_txSent) begin
            r_txFrame <= {1'b1, NAK_BYTE, 1'b0};
            r_txClk   <= '0;
            r_txBit   <= '0;
            r_txBusy  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx    = r_txFrame[0];
  assign wen   = r_wen;
  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign done  = (r_state == ST_DONE);
  assign err   = (r_state == ST_ERROR);
  assign busy  = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERROR);

endmodule
